rob_mem_port: RTL and testbench
===============================

ROB_MEM_PORT -- requirements
Module: rob_mem_port

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low. Ports are named clk and rst, and rst=0 resets the block.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-low.
REQ-004 rdy  input  1  global enable; when low, all state holds.
REQ-005 if_out_mem  input  1  one-cycle store request from the ROB commit stage.
REQ-006 out_mem_size  input  6  store byte count; legal values are 1, 2 and 4.
REQ-007 out_mem_addr  input  32  store start address.
REQ-008 out_mem_data  input  32  store data; byte k = bits [8k+7:8k].
REQ-009 if_out_mem_io  input  1  one-cycle IO-load request; the address is fixed at 0x30000.
REQ-010 clear_mem  input  1  flush of pending, not-yet-started requests.
REQ-011 if_get_mem  output  1  one-cycle completion pulse to the ROB.
REQ-012 data_mem  output  32  IO-load result, zero-extended byte; valid while if_get_mem=1.
REQ-013 mem_din  input  8  RAM/IO read byte, valid one cycle after its address is driven.
REQ-014 mem_dout  output  8  write byte.
REQ-015 mem_a  output  32  RAM/IO byte address.
REQ-016 mem_wr  output  1  1 = write, 0 = read.
REQ-017 io_buffer_full  input  1  UART transmit buffer full.

Function
REQ-018 The block SHALL implement the states IDLE, STORE, IO_ADDR, IO_DATA and DONE.
- REQ-019 IDLE SHALL sample the requests at each edge.
  - if_out_mem=1 -> STORE; latch addr, data and size; byte counter k=0.
  - else if_out_mem_io=1 -> IO_ADDR.
  - If both are asserted in the same cycle, the store SHALL win and the IO request SHALL be dropped.
- REQ-020 STORE SHALL behave per cycle as follows:
  - Drive mem_a=addr+k (mod 2^32), mem_dout=byte k, mem_wr=1.
  - Advance k; after byte size-1 -> DONE.
  - Bytes SHALL be written little-endian, one per cycle.
- REQ-021 IO write stall: in STORE, if addr[17:16]=2'b11 and io_buffer_full=1, then:
  - mem_wr=0;
  - k SHALL NOT advance;
  - the same byte SHALL be retried the next cycle.
  - io_buffer_full SHALL be ignored for RAM addresses.
- REQ-022 Illegal store size (not 1, 2 or 4): no byte is written; go directly to DONE.
- REQ-023 IO_ADDR SHALL drive mem_a=0x30000 and mem_wr=0 for exactly one cycle, then go to IO_DATA.
  - The IO address SHALL be read exactly once per request, because reading it consumes input.
- REQ-024 IO_DATA SHALL capture data_mem={24'b0, mem_din}, drive mem_a=0 and mem_wr=0, then go to DONE.
- REQ-025 DONE SHALL assert if_get_mem=1 for exactly one cycle, then go to IDLE.
  - if_get_mem SHALL be 0 in every other state.
- REQ-026 Latency, with the request sampled at edge 0:
  - An N-byte RAM store writes on cycles 1..N and pulses if_get_mem in cycle N+1.
  - An IO load drives the address in cycle 1, captures data in cycle 2 and pulses if_get_mem in cycle 3.
- REQ-027 Requests arriving outside IDLE SHALL be ignored and SHALL NOT be queued.
- REQ-028 clear_mem=1 in IDLE SHALL drop any request sampled in that same cycle.
  - In all other states clear_mem SHALL be ignored, so committed stores and started IO reads always complete.
- REQ-029 Outside STORE, mem_wr SHALL be 0 and mem_dout SHALL hold its last value.
- REQ-030 rdy=0 SHALL freeze state, k and the latched request, and SHALL force mem_wr=0.
  - The write SHALL resume at the same byte when rdy returns to 1.
  - if_get_mem SHALL be held off while rdy=0 and pulse on the first rdy=1 cycle.
- REQ-031 data_mem SHALL hold its last captured value until the next IO load.

Reset
REQ-032 With rst=0 at an edge, the block SHALL enter IDLE and clear k.
- REQ-033 The reset values of all outputs SHALL be if_get_mem=0, data_mem=0, mem_a=0, mem_dout=0, mem_wr=0.
- REQ-034 Reset SHALL take priority over rdy and over any in-flight operation.
  - A partial store SHALL stop immediately and produce no completion pulse.

Verification
REQ-035 SW store: addr=0x1000, data=0xAABBCCDD, size=4 -> the following writes on cycles 1-4, then if_get_mem on cycle 5:

| Cycle | mem_a | mem_dout |
|---|---|---|
| 1 | 0x1000 | 0xDD |
| 2 | 0x1001 | 0xCC |
| 3 | 0x1002 | 0xBB |
| 4 | 0x1003 | 0xAA |

REQ-036 SB to IO: addr=0x30004, data=0x41, size=1, with io_buffer_full=1 for 3 cycles -> mem_wr=0 for 3 cycles, then a single write of 0x41 to 0x30004, then if_get_mem.
REQ-037 IO load with mem_din=0x7F one cycle after address 0x30000 -> exactly one read of 0x30000, then data_mem=0x0000007F with if_get_mem on cycle 3.
REQ-038 Address and request edge cases:
- Store at addr=0xFFFFFFFF, size=2 -> writes to 0xFFFFFFFF, then 0x00000000.
- if_out_mem and if_out_mem_io asserted together -> only the store executes.
REQ-039 rst=0 asserted during byte 2 of an SW store -> next cycle mem_wr=0 and state IDLE, with no if_get_mem pulse; a new SH store afterwards completes in 3 cycles.
REQ-040 rdy=0 for 2 cycles mid-store, and clear_mem=1 asserted together with if_out_mem in IDLE:
- The rdy stall -> byte order is preserved and there are no duplicate writes.
- The clear_mem case -> the request is dropped and no write occurs.

Source files
------------

// File: rtl/rob_mem_port.sv
// rob_mem_port: byte-serial memory port for ROB stores and single-byte IO loads.
// Ports: clk/rst (sync, active-low), rdy (global enable);
//        if_out_mem/out_mem_size/out_mem_addr/out_mem_data (store request);
//        if_out_mem_io (IO load request), clear_mem (flush in IDLE), io_buffer_full (UART full);
//        if_get_mem/data_mem (completion pulse and IO load result);
//        mem_din/mem_dout/mem_a/mem_wr (byte-wide RAM/IO bus).
module rob_mem_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_out_mem,
    input  logic [5:0]  out_mem_size,
    input  logic [31:0] out_mem_addr,
    input  logic [31:0] out_mem_data,
    input  logic        if_out_mem_io,
    input  logic        clear_mem,
    output logic        if_get_mem,
    output logic [31:0] data_mem,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [2:0] {IDLE, STORE, IO_ADDR, IO_DATA, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d, last_q, last_d;
    logic [31:0] addr_q, addr_d, data_q, data_d, dmem_q, dmem_d;
    logic [7:0]  dout_q, dout_d, byte_k;
    logic        stall, legal;
    assign byte_k = data_q[{k_q, 3'b000} +: 8];
    // UART writes back-pressure only when the target lies in the IO window
    assign stall = (addr_q[17:16] == 2'b11) && io_buffer_full;
    assign legal = (out_mem_size == 6'd1) || (out_mem_size == 6'd2) || (out_mem_size == 6'd4);
    assign mem_wr = rdy && (state_q == STORE) && !stall;
    assign mem_a = (state_q == STORE) ? addr_q + {30'b0, k_q} :
                   (state_q == IO_ADDR) ? 32'h0003_0000 : 32'h0;
    assign mem_dout = (state_q == STORE) ? byte_k : dout_q;
    assign if_get_mem = rdy && (state_q == DONE);
    assign data_mem = dmem_q;
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        dmem_d  = dmem_q;
        dout_d  = (state_q == STORE) ? byte_k : dout_q;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (!clear_mem && if_out_mem) begin
                        addr_d  = out_mem_addr;
                        data_d  = out_mem_data;
                        // last byte index: 1->0, 2->1, 4->3
                        last_d  = out_mem_size[1:0] - 2'd1;
                        k_d     = 2'd0;
                        state_d = legal ? STORE : DONE;
                    end else if (!clear_mem && if_out_mem_io) begin
                        state_d = IO_ADDR;
                    end
                end
                STORE: begin
                    if (!stall) begin
                        k_d     = k_q + 2'd1;
                        state_d = (k_q == last_q) ? DONE : STORE;
                    end
                end
                IO_ADDR: state_d = IO_DATA;
                IO_DATA: begin
                    dmem_d  = {24'b0, mem_din};
                    state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            last_q  <= 2'd0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            dmem_q  <= 32'h0;
            dout_q  <= 8'h0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dmem_q  <= dmem_d;
            dout_q  <= dout_d;
        end
    end
endmodule

// File: tb/tb_rob_mem_port.sv
// tb_rob_mem_port: directed self-checking bench for rob_mem_port.
module tb_rob_mem_port;
    logic        clk = 0, rst = 0, rdy = 1;
    logic        if_out_mem = 0, if_out_mem_io = 0, clear_mem = 0, io_buffer_full = 0;
    logic [5:0]  out_mem_size = 0;
    logic [31:0] out_mem_addr = 0, out_mem_data = 0;
    logic [7:0]  mem_din = 0;
    logic        if_get_mem, mem_wr;
    logic [31:0] data_mem, mem_a;
    logic [7:0]  mem_dout;
    int checks = 0, errors = 0;

    rob_mem_port dut (
        .clk(clk), .rst(rst), .rdy(rdy), .if_out_mem(if_out_mem),
        .out_mem_size(out_mem_size), .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
        .if_out_mem_io(if_out_mem_io), .clear_mem(clear_mem), .if_get_mem(if_get_mem),
        .data_mem(data_mem), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic store_req(input logic [31:0] a, input logic [31:0] d, input logic [5:0] s);
        if_out_mem = 1; out_mem_addr = a; out_mem_data = d; out_mem_size = s;
        nxt();
        if_out_mem = 0;
    endtask

    task automatic expect_wr(input string tag, input logic [31:0] a, input logic [7:0] d);
        #1;
        chk({tag, ".wr"}, mem_wr, 1);
        chk({tag, ".a"}, mem_a, a);
        chk({tag, ".dout"}, mem_dout, d);
        chk({tag, ".get"}, if_get_mem, 0);
        nxt();
    endtask

    task automatic expect_done(input string tag);
        #1;
        chk({tag, ".done_get"}, if_get_mem, 1);
        chk({tag, ".done_wr"}, mem_wr, 0);
        nxt();
        #1;
        chk({tag, ".idle_get"}, if_get_mem, 0);
        chk({tag, ".idle_a"}, mem_a, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst.get", if_get_mem, 0);
        chk("rst.data", data_mem, 0);
        chk("rst.a", mem_a, 0);
        chk("rst.dout", mem_dout, 0);
        chk("rst.wr", mem_wr, 0);
        rst = 1;
        nxt();

        store_req(32'h1000, 32'hAABBCCDD, 4);
        expect_wr("sw0", 32'h1000, 8'hDD);
        expect_wr("sw1", 32'h1001, 8'hCC);
        expect_wr("sw2", 32'h1002, 8'hBB);
        expect_wr("sw3", 32'h1003, 8'hAA);
        expect_done("sw");
        chk("sw.dout_hold", mem_dout, 8'hAA);
        chk("sw.idle_wr", mem_wr, 0);
        nxt();

        io_buffer_full = 1;
        store_req(32'h30004, 32'h41, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sbio.stall_wr", mem_wr, 0);
            chk("sbio.stall_a", mem_a, 32'h30004);
            nxt();
        end
        io_buffer_full = 0;
        expect_wr("sbio", 32'h30004, 8'h41);
        expect_done("sbio");
        nxt();

        if_out_mem_io = 1;
        nxt();
        if_out_mem_io = 0;
        #1;
        chk("io.c1_a", mem_a, 32'h30000);
        chk("io.c1_wr", mem_wr, 0);
        chk("io.c1_get", if_get_mem, 0);
        nxt();
        mem_din = 8'h7F;
        #1;
        chk("io.c2_a", mem_a, 0);
        chk("io.c2_wr", mem_wr, 0);
        chk("io.c2_get", if_get_mem, 0);
        nxt();
        mem_din = 8'h00;
        #1;
        chk("io.c3_data", data_mem, 32'h7F);
        expect_done("io");
        chk("io.data_hold", data_mem, 32'h7F);
        nxt();

        store_req(32'hFFFF_FFFF, 32'h1234, 2);
        expect_wr("wrap0", 32'hFFFF_FFFF, 8'h34);
        expect_wr("wrap1", 32'h0, 8'h12);
        expect_done("wrap");
        nxt();

        if_out_mem_io = 1;
        store_req(32'h2000, 32'h55, 1);
        if_out_mem_io = 0;
        expect_wr("both", 32'h2000, 8'h55);
        expect_done("both");
        nxt();
        #1;
        chk("both.no_io_a", mem_a, 0);
        nxt();

        store_req(32'h3000, 32'h11223344, 4);
        expect_wr("rsta0", 32'h3000, 8'h44);
        #1;
        chk("rsta1.wr", mem_wr, 1);
        chk("rsta1.a", mem_a, 32'h3001);
        rst = 0;
        nxt();
        rst = 1;
        #1;
        chk("rsta.wr", mem_wr, 0);
        chk("rsta.a", mem_a, 0);
        chk("rsta.dout", mem_dout, 0);
        chk("rsta.get", if_get_mem, 0);
        nxt();
        #1;
        chk("rsta.get2", if_get_mem, 0);
        chk("rsta.wr2", mem_wr, 0);
        nxt();
        store_req(32'h4000, 32'hBEEF, 2);
        expect_wr("sh0", 32'h4000, 8'hEF);
        expect_wr("sh1", 32'h4001, 8'hBE);
        expect_done("sh");
        nxt();

        store_req(32'h5000, 32'h89ABCDEF, 4);
        expect_wr("rdy0", 32'h5000, 8'hEF);
        rdy = 0;
        #1;
        chk("rdy.s1_wr", mem_wr, 0);
        nxt();
        #1;
        chk("rdy.s2_wr", mem_wr, 0);
        nxt();
        rdy = 1;
        expect_wr("rdy1", 32'h5001, 8'hCD);
        expect_wr("rdy2", 32'h5002, 8'hAB);
        expect_wr("rdy3", 32'h5003, 8'h89);
        rdy = 0;
        #1;
        chk("rdy.done_held", if_get_mem, 0);
        nxt();
        rdy = 1;
        expect_done("rdy");
        nxt();

        clear_mem = 1;
        store_req(32'h6000, 32'hCAFEF00D, 4);
        clear_mem = 0;
        #1;
        chk("clr.wr", mem_wr, 0);
        chk("clr.a", mem_a, 0);
        nxt();
        #1;
        chk("clr.wr2", mem_wr, 0);
        chk("clr.get", if_get_mem, 0);
        nxt();

        store_req(32'h7000, 32'hFF, 3);
        #1;
        chk("ill.wr", mem_wr, 0);
        chk("ill.get", if_get_mem, 1);
        nxt();
        #1;
        chk("ill.get2", if_get_mem, 0);
        nxt();

        store_req(32'h8000, 32'hA5C3, 2);
        if_out_mem_io = 1;
        expect_wr("busy0", 32'h8000, 8'hC3);
        if_out_mem_io = 0;
        expect_wr("busy1", 32'h8001, 8'hA5);
        expect_done("busy");
        nxt();
        #1;
        chk("busy.no_io_a", mem_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
